// File: rtl/umi_addr_router_pkg.sv
// Shared UMI packet field layout and dstaddr extraction.
// Also holds the router's default port-select field position.
package umi_addr_router_pkg;

    localparam int unsigned UmiPktW    = 256;

    localparam int unsigned UmiCmdLsb  = 0;
    localparam int unsigned UmiCmdW    = 8;
    localparam int unsigned UmiSizeLsb = UmiCmdLsb + UmiCmdW;
    localparam int unsigned UmiSizeW   = 4;
    localparam int unsigned UmiOptLsb  = UmiSizeLsb + UmiSizeW;
    localparam int unsigned UmiOptW    = 20;
    localparam int unsigned UmiDstLsb  = UmiOptLsb + UmiOptW;
    localparam int unsigned UmiDstW    = 64;
    localparam int unsigned UmiSrcLsb  = UmiDstLsb + UmiDstW;
    localparam int unsigned UmiSrcW    = 64;
    localparam int unsigned UmiDataLsb = UmiSrcLsb + UmiSrcW;
    localparam int unsigned UmiDataW   = UmiPktW - UmiDataLsb;

    localparam int unsigned RouterSelLsb = 40;
    localparam int unsigned RouterSelW   = 2;

    typedef logic [UmiDstW-1:0] umi_addr_t;

    function automatic umi_addr_t umi_get_dstaddr(input logic [UmiPktW-1:0] packet);
        return packet[UmiDstLsb +: UmiDstW];
    endfunction

endpackage

// File: rtl/umi_addr_router_if.sv
// Router-side bundle: one input UMI stream and N output UMI streams.
interface umi_addr_router_if #(
    parameter int unsigned UW = 256,
    parameter int unsigned N  = 4
);

    logic            umi_in_valid;
    logic [UW-1:0]   umi_in_packet;
    logic            umi_in_ready;
    logic [N-1:0]    umi_out_valid;
    logic [N*UW-1:0] umi_out_packet;
    logic [N-1:0]    umi_out_ready;

    modport master (
        output umi_in_valid,
        output umi_in_packet,
        input  umi_in_ready,
        input  umi_out_valid,
        input  umi_out_packet,
        output umi_out_ready
    );

    modport slave (
        input  umi_in_valid,
        input  umi_in_packet,
        output umi_in_ready,
        output umi_out_valid,
        output umi_out_packet,
        input  umi_out_ready
    );

endinterface

// File: rtl/umi_pipe_reg.sv
// Single-entry valid/ready register with pass-through ready:
// accepts a new word in the same cycle the held one drains.
module umi_pipe_reg #(
    parameter int unsigned W = 8
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         in_valid_i,
    input  logic [W-1:0] in_data_i,
    output logic         in_ready_o,
    output logic         out_valid_o,
    output logic [W-1:0] out_data_o,
    input  logic         out_ready_i
);

    logic         full_q, full_d;
    logic [W-1:0] data_q;
    logic         load;

    assign in_ready_o  = ~full_q | out_ready_i;
    assign load        = in_valid_i & in_ready_o;
    assign out_valid_o = full_q;
    assign out_data_o  = data_q;

    always_comb begin
        full_d = full_q;
        if (load) begin
            full_d = 1'b1;
        end else if (out_ready_i) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            full_q <= 1'b0;
        end else begin
            full_q <= full_d;
        end
    end

    // Payload needs no reset; it is only observed while full_q is set.
    always_ff @(posedge clk_i) begin
        if (load) begin
            data_q <= in_data_i;
        end
    end

endmodule

// File: rtl/umi_addr_router.sv
// Routes each UMI packet to one of N outputs by a dstaddr bit-field, through a
// one-deep register; out-of-range packets are dropped and counted.
module umi_addr_router
    import umi_addr_router_pkg::*;
#(
    parameter int unsigned AW     = 64,
    parameter int unsigned UW     = 256,
    parameter int unsigned N      = 4,
    parameter int unsigned SELW   = RouterSelW,
    parameter int unsigned SELLSB = RouterSelLsb,
    parameter int unsigned CW     = 16
) (
    input  logic                clk,
    input  logic                reset,
    umi_addr_router_if.slave    umi,
    output logic                err_pulse,
    output logic [CW-1:0]       err_count
);

    logic [AW-1:0]   dstaddr;
    logic [SELW-1:0] sel;
    logic            in_range;
    logic            drop;
    logic            pipe_in_valid;
    logic            full;
    logic [SELW-1:0] sel_q;
    logic [UW-1:0]   packet_q;
    logic            out_ready_sel;
    logic            err_pulse_q;
    logic [CW-1:0]   err_count_q, err_count_d;

    assign dstaddr = AW'(umi_get_dstaddr(umi.umi_in_packet[UmiPktW-1:0]));
    assign sel     = SELW'(dstaddr >> SELLSB);

    // Explicit compare loop keeps N legal when it is not a power of two.
    always_comb begin
        in_range = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (sel == SELW'(i)) begin
                in_range = 1'b1;
            end
        end
    end

    assign pipe_in_valid = umi.umi_in_valid & in_range;
    assign drop          = umi.umi_in_valid & umi.umi_in_ready & ~in_range;

    umi_pipe_reg #(
        .W (UW + SELW)
    ) u_pipe (
        .clk_i       (clk),
        .reset_i     (reset),
        .in_valid_i  (pipe_in_valid),
        .in_data_i   ({sel, umi.umi_in_packet}),
        .in_ready_o  (umi.umi_in_ready),
        .out_valid_o (full),
        .out_data_o  ({sel_q, packet_q}),
        .out_ready_i (out_ready_sel)
    );

    always_comb begin
        umi.umi_out_valid = '0;
        out_ready_sel     = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (sel_q == SELW'(i)) begin
                umi.umi_out_valid[i] = full;
                out_ready_sel        = umi.umi_out_ready[i];
            end
        end
    end

    assign umi.umi_out_packet = {N{packet_q}};

    always_comb begin
        err_count_d = err_count_q;
        if (drop && !(&err_count_q)) begin
            err_count_d = err_count_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            err_pulse_q <= 1'b0;
            err_count_q <= '0;
        end else begin
            err_pulse_q <= drop;
            err_count_q <= err_count_d;
        end
    end

    assign err_pulse = err_pulse_q;
    assign err_count = err_count_q;

endmodule
